// File: rtl/stream_check_pkg.sv
// Shared types and constants for the stream sequence checker.
// Holds the FSM state encoding, the LFSR seed and the Fibonacci tap mask.
package stream_check_pkg;

  localparam int unsigned LFSR_W = 16;

  // Seed reloaded on reset and at every accepted start.
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  // Taps for x^16+x^14+x^13+x^11+1 in a right-shifting Fibonacci register.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random backpressure.
// Reload has priority over stepping.
module lfsr16
  import stream_check_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              en_i,
  output logic [LFSR_W-1:0] state_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_o <= LFSR_SEED;
    end else if (load_i) begin
      state_o <= LFSR_SEED;
    end else if (en_i) begin
      state_o <= lfsr_step(state_o);
    end
  end

endmodule

// File: rtl/stream_seq_checker.sv
// Consumes a fixed-length stream and checks it against an incrementing sequence.
// Counts mismatches and records the index of the first one.
module stream_seq_checker
  import stream_check_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] num_i,
  input  logic [WIDTH-1:0]   first_i,
  input  logic               stall_en_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [COUNT_W-1:0] err_count_o,
  output logic               first_err_valid_o,
  output logic [COUNT_W-1:0] first_err_idx_o
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [COUNT_W-1:0] num_q, num_d;
  logic [COUNT_W-1:0] err_count_d;
  logic               first_err_valid_d;
  logic [COUNT_W-1:0] first_err_idx_d;
  logic               start_accept;
  logic               handshake;
  logic [LFSR_W-1:0]  lfsr_state;
  logic               unused_lfsr;

  lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (start_accept),
    .en_i    (state_q == ST_RUN),
    .state_o (lfsr_state)
  );

  // Only bit 0 drives backpressure; the rest is feedback state.
  assign unused_lfsr = ^lfsr_state[LFSR_W-1:1];

  // Decoded from registered state only, so valid_i never reaches ready_o.
  assign ready_o = (state_q == ST_RUN) && (!stall_en_i || !lfsr_state[0]);

  always_comb begin
    state_d           = state_q;
    expected_d        = expected_q;
    idx_d             = idx_q;
    num_d             = num_q;
    err_count_d       = err_count_o;
    first_err_valid_d = first_err_valid_o;
    first_err_idx_d   = first_err_idx_o;
    start_accept      = 1'b0;
    handshake         = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          start_accept      = 1'b1;
          num_d             = num_i;
          expected_d        = first_i;
          idx_d             = '0;
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_idx_d   = '0;
          state_d           = (num_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        handshake = valid_i && ready_o;
        if (handshake) begin
          expected_d = expected_q + WIDTH'(1);
          idx_d      = idx_q + COUNT_W'(1);
          if (data_i != expected_q) begin
            if (err_count_o != '1) begin
              err_count_d = err_count_o + COUNT_W'(1);
            end
            if (!first_err_valid_o) begin
              first_err_valid_d = 1'b1;
              first_err_idx_d   = idx_q;
            end
          end
          // Final word's result lands in the same edge as the move to DONE.
          if (idx_q == COUNT_W'(num_q - COUNT_W'(1))) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= ST_IDLE;
      expected_q        <= '0;
      idx_q             <= '0;
      num_q             <= '0;
      err_count_o       <= '0;
      first_err_valid_o <= 1'b0;
      first_err_idx_o   <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      state_q           <= state_d;
      expected_q        <= expected_d;
      idx_q             <= idx_d;
      num_q             <= num_d;
      err_count_o       <= err_count_d;
      first_err_valid_o <= first_err_valid_d;
      first_err_idx_o   <= first_err_idx_d;
      busy_o            <= (state_d == ST_RUN);
      done_o            <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Self-checking bench for stream_seq_checker: behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_stream_seq_checker;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned COUNT_W = 32;

  logic               clk      = 1'b0;
  logic               rst      = 1'b0;
  logic               start    = 1'b0;
  logic [COUNT_W-1:0] num      = '0;
  logic [WIDTH-1:0]   first    = '0;
  logic               stall_en = 1'b0;
  logic [WIDTH-1:0]   data     = '0;
  logic               valid    = 1'b0;
  logic               ready, busy, done, fev;
  logic [COUNT_W-1:0] err, fei;

  stream_seq_checker #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .num_i             (num),
    .first_i           (first),
    .stall_en_i        (stall_en),
    .data_i            (data),
    .valid_i           (valid),
    .ready_o           (ready),
    .busy_o            (busy),
    .done_o            (done),
    .err_count_o       (err),
    .first_err_valid_o (fev),
    .first_err_idx_o   (fei)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_e;
  mphase_e          m_phase     = M_IDLE;
  logic [15:0]      m_lfsr      = 16'hACE1;
  logic [WIDTH-1:0] m_next_word = '0;
  int unsigned      m_consumed  = 0;
  int unsigned      m_target    = 0;
  int unsigned      m_bad       = 0;
  logic             m_bad_seen  = 1'b0;
  int unsigned      m_first_bad = 0;

  function automatic logic model_ready();
    return (m_phase == M_RUN) && !(stall_en && m_lfsr[0]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = M_IDLE; m_lfsr = 16'hACE1; m_next_word = '0;
      m_consumed = 0; m_target = 0; m_bad = 0; m_bad_seen = 1'b0; m_first_bad = 0;
    end else if (m_phase == M_RUN) begin
      if (valid && model_ready()) begin
        if (data !== m_next_word) begin
          if (m_bad != 32'hFFFF_FFFF) m_bad++;
          if (!m_bad_seen) begin
            m_bad_seen  = 1'b1;
            m_first_bad = m_consumed;
          end
        end
        m_next_word++;
        m_consumed++;
        if (m_consumed == m_target) m_phase = M_DONE;
      end
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end else if (start) begin
      m_target = num; m_next_word = first; m_consumed = 0;
      m_bad = 0; m_bad_seen = 1'b0; m_first_bad = 0; m_lfsr = 16'hACE1;
      m_phase = (num == 0) ? M_DONE : M_RUN;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        cmp_en    = 1'b0;
  logic        done_seen = 1'b0;
  int unsigned dut_hs    = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", 32'(ready), 32'(model_ready()));
      chk("busy", 32'(busy), 32'(m_phase == M_RUN));
      chk("done", 32'(done), 32'(m_phase == M_DONE));
      chk("err_count", err, m_bad);
      chk("first_err_valid", 32'(fev), 32'(m_bad_seen));
      chk("first_err_idx", fei, m_first_bad);
      if (valid && ready) dut_hs++;
      if (done) done_seen = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] src[$];
  logic [5:0]       lfsr_ready_pat = 6'b011110;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [COUNT_W-1:0] n, input logic [WIDTH-1:0] f,
                     input logic stall, input int vgap, input int inj_at, input int abort_at);
    int   cycles;
    logic r1, r2;
    stall_en = stall; start = 1'b1; num = n; first = f;
    tick();
    start = 1'b0;
    cycles = 0;
    while (m_phase == M_RUN && cycles < 5000) begin
      if (abort_at >= 0 && m_consumed == abort_at) break;
      data  = (m_consumed < src.size()) ? src[m_consumed] : '0;
      valid = (vgap == 0) || (cycles % vgap != 0);
      if (cycles == inj_at) begin
        start = 1'b1; num = 32'd2; first = 32'd100;
      end else begin
        start = 1'b0;
      end
      if (stall && cycles < 6) chk("lfsr_ready_seq", 32'(ready), 32'(lfsr_ready_pat[cycles]));
      if (stall && cycles < 16) begin
        #1 r1 = ready;
        valid = ~valid;
        #1 r2 = ready;
        valid = ~valid;
        chk("ready_vs_valid", 32'(r2), 32'(r1));
      end
      tick();
      cycles++;
    end
    valid = 1'b0; start = 1'b0;
    if (abort_at < 0 && m_phase == M_RUN) begin
      n_checks++; n_errors++;
      $display("FAIL run_timeout: still busy after %0d cycles", cycles);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hs0;
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_fev", 32'(fev), 32'd0);
    chk("rst_fei", fei, 32'd0);
    tick();

    // 8 clean words, no stall; a start pulse mid-run must be ignored
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(32'(i));
    hs0 = dut_hs;
    run(32'd8, 32'd0, 1'b0, 0, 3, -1);
    chk("t1_handshakes", 32'(dut_hs - hs0), 32'd8);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", err, 32'd0);

    // wrap-around of the expected value
    src = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    run(32'd4, 32'hFFFF_FFFE, 1'b0, 0, -1, -1);
    chk("t3_err", err, 32'd0);
    chk("t3_done", 32'(done), 32'd1);

    // pseudo-random backpressure, gappy valid, 1000 words
    src.delete();
    for (int i = 0; i < 1000; i++) src.push_back(32'(i));
    hs0 = dut_hs;
    run(32'd1000, 32'd0, 1'b1, 5, -1, -1);
    chk("t4_handshakes", 32'(dut_hs - hs0), 32'd1000);
    chk("t4_err", err, 32'd0);
    chk("t4_done", 32'(done), 32'd1);

    // two mismatches
    src = '{32'd10, 32'd11, 32'd99, 32'd13, 32'd77};
    run(32'd5, 32'd10, 1'b0, 0, -1, -1);
    chk("t2_err", err, 32'd2);
    chk("t2_fei", fei, 32'd2);
    chk("t2_fev", 32'(fev), 32'd1);

    // zero-length run from DONE clears counters
    hs0 = dut_hs;
    stall_en = 1'b0; start = 1'b1; num = '0; first = 32'd5;
    tick();
    start = 1'b0;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_err", err, 32'd0);
    chk("t5_fev", 32'(fev), 32'd0);
    tick();
    chk("t5_handshakes", 32'(dut_hs - hs0), 32'd0);
    src = '{32'd7, 32'd8, 32'd20};
    run(32'd3, 32'd7, 1'b0, 0, -1, -1);
    chk("t5b_err", err, 32'd1);
    chk("t5b_fei", fei, 32'd2);

    // reset mid-run after 4 words with one mismatch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done_seen = 1'b0;
    src = '{32'd0, 32'd1, 32'd9, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    run(32'd8, 32'd0, 1'b0, 0, -1, 4);
    chk("t6_err_before", err, 32'd1);
    chk("t6_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(ready), 32'd0);
    chk("t6_err", err, 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    tick(); tick(); tick();
    chk("t6_done_never", 32'(done_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_seq_checker.md
STREAM_SEQ_CHECKER -- requirements
Module: stream_seq_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter COUNT_W, default 32, width of the count, index and error counters.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, starts a check run (sampled in IDLE or DONE).
REQ-006 SHALL have port num_i, input, COUNT_W, number of words to consume (sampled with start_i).
REQ-007 SHALL have port first_i, input, WIDTH, expected value of the first word (sampled with start_i).
REQ-008 SHALL have port stall_en_i, input, 1, enables pseudo-random backpressure.
REQ-009 SHALL have port data_i, input, WIDTH, stream data.
REQ-010 SHALL have port valid_i, input, 1, stream valid.
REQ-011 SHALL have port ready_o, output, 1, stream ready.
REQ-012 SHALL have port busy_o, output, 1, high while in RUN.
REQ-013 SHALL have port done_o, output, 1, high while in DONE.
REQ-014 SHALL have port err_count_o, output, COUNT_W, number of mismatching words in the current or last run.
REQ-015 SHALL have port first_err_valid_o, output, 1, at least one mismatch has been recorded.
REQ-016 SHALL have port first_err_idx_o, output, COUNT_W, index of the first mismatching word.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 SHALL perform the following transitions: IDLE or DONE with start_i=1 -> RUN, or -> DONE when num_i==0; RUN -> DONE on the handshake at index num-1; otherwise hold.
REQ-019 SHALL, on start_i, latch num_i, load expected<=first_i and idx<=0, and clear err_count_o, first_err_valid_o and first_err_idx_o in that same edge.
REQ-020 SHALL drive ready_o=0 in IDLE and DONE.
REQ-021 SHALL drive ready_o=1 in RUN when stall_en_i=0, and ready_o=~lfsr[0] in RUN when stall_en_i=1.
REQ-022 SHALL make ready_o a registered-state function with no combinational dependence on valid_i.
REQ-023 SHALL define a handshake as valid_i & ready_o in RUN; exactly one word is consumed per handshake.
REQ-024 SHALL, on each handshake, compare data_i to expected; expected<=expected+1 modulo 2^WIDTH (wraps, no saturation); idx<=idx+1.
REQ-025 SHALL, on a mismatch, increment err_count_o, saturating at all-ones.
REQ-026 SHALL, on the first mismatch of a run, set first_err_valid_o<=1 and first_err_idx_o<=idx; later mismatches leave both unchanged.
REQ-027 SHALL register the result of the final word's comparison in the same edge as the RUN->DONE transition, so done_o rising means err_count_o is final.
REQ-028 SHALL, on start_i while in RUN, ignore start_i and let the run continue.
REQ-029 SHALL advance the LFSR every cycle in RUN, independent of the handshake, and hold it otherwise.
REQ-030 SHALL use LFSR polynomial x^16+x^14+x^13+x^11+1 (Fibonacci form), with the LFSR reseeded to 16'hACE1 on start_i.
REQ-031 SHALL have latency zero: data_i presented with a handshake is consumed and checked in that cycle; no internal buffering.

Reset
REQ-032 SHALL, with rst_i=1 at a rising edge, enter IDLE and apply LFSR=16'hACE1, expected=0, idx=0, num=0 and err_count_o=0.
REQ-033 SHALL, in that same reset, apply first_err_valid_o=0, first_err_idx_o=0, ready_o=0, busy_o=0 and done_o=0.
REQ-034 SHALL, on reset mid-RUN, abort the run immediately; no done_o pulse is produced and the partial error count is discarded.
REQ-035 SHALL give rst_i priority over start_i in the same cycle.

Structure
REQ-036 SHALL place the state enum (IDLE/RUN/DONE), the LFSR seed constant and the LFSR tap mask in shared package stream_check_pkg.
REQ-037 SHALL contain one sub-module, lfsr16 (ports: clk_i, rst_i, load_i, en_i, state_o), with sync active-high reset.

Verification
REQ-038 SHALL cover: WIDTH=32, start with num=8, first=0, stall_en=0, source drives 0..7 with valid always 1 -> 8 consecutive handshakes, done_o after the 8th, err_count_o=0.
REQ-039 SHALL cover: num=5, first=10, source sends 10,11,99,13,77 -> err_count_o=2, first_err_idx_o=2, first_err_valid_o=1.
REQ-040 SHALL cover: first=32'hFFFF_FFFE, num=4, source sends FFFF_FFFE, FFFF_FFFF, 0, 1 -> err_count_o=0 (wrap-around).
REQ-041 SHALL cover: stall_en=1, num=1000, correct incrementing data -> ready_o toggles per the LFSR sequence from seed ACE1; exactly 1000 handshakes; err_count_o=0; ready_o never depends on valid_i.
REQ-042 SHALL cover: start num=0 -> DONE next cycle, no handshakes, err_count_o=0; then start_i in DONE with num=3 -> new run with counters cleared.
REQ-043 SHALL cover: rst_i asserted after 4 of 8 words, with one prior mismatch -> next cycle IDLE, err_count_o=0, ready_o=0, done_o never asserted.
